f8_alu_wide_seq: RTL and testbench

//  Multi-cycle, byte-serial ALU for operands of BYTES*8 bits, using the F8 op encodings from f8_ops.vh.

---
 rtl/f8_alu_wide_seq.sv | 256 +++++++++++++++++++++++++
 tb/tb_f8_alu_wide_seq.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/f8_alu_wide_seq.sv
// ============================================================================
//  Module      : f8_alu_wide_seq
//  Description : Byte-serial multi-cycle ALU for 8*BYTES-bit operands using
//                the F8 op encodings. One byte slice is processed per clock,
//                with carry/shift bits chained between slices. The result and
//                the C/Z/OV/S flags are registered and presented with a
//                one-cycle done pulse.
//                Optional macro F8_ALU_WIDE_BCD_EN enables decimal ADD_BCD;
//                without it ADD_BCD behaves as binary ADD.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module f8_alu_wide_seq #(
    parameter int BYTES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [3:0]           op,
    input  logic [8*BYTES-1:0]   left,
    input  logic [8*BYTES-1:0]   right,
    input  logic                 c_in,
    output logic                 busy,
    output logic                 done,
    output logic [8*BYTES-1:0]   result,
    output logic                 c,
    output logic                 z,
    output logic                 ov,
    output logic                 s
);

    localparam int W  = 8 * BYTES;
    localparam int KW = (BYTES > 1) ? $clog2(BYTES) : 1;

    // F8 ALU op encodings
    localparam logic [3:0] c_ALU_ADD     = 4'd0;
    localparam logic [3:0] c_ALU_ADD_BCD = 4'd1;
    localparam logic [3:0] c_ALU_INC     = 4'd2;
    localparam logic [3:0] c_ALU_LINK    = 4'd3;
    localparam logic [3:0] c_ALU_CMP     = 4'd4;
    localparam logic [3:0] c_ALU_DEC_R   = 4'd5;
    localparam logic [3:0] c_ALU_AND     = 4'd6;
    localparam logic [3:0] c_ALU_OR      = 4'd7;
    localparam logic [3:0] c_ALU_XOR     = 4'd8;
    localparam logic [3:0] c_ALU_COM     = 4'd9;
    localparam logic [3:0] c_ALU_SL_1    = 4'd10;
    localparam logic [3:0] c_ALU_SL_4    = 4'd11;
    localparam logic [3:0] c_ALU_SR_1    = 4'd12;
    localparam logic [3:0] c_ALU_SR_4    = 4'd13;
    localparam logic [3:0] c_ALU_L       = 4'd14;
    localparam logic [3:0] c_ALU_R       = 4'd15;

    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_RUN  = 1'b1;

    logic [0:0]     r_state;
    logic [0:0]     w_state_next;
    logic [KW-1:0]  r_k;
    logic [3:0]     r_op;
    logic [W-1:0]   r_left;
    logic [W-1:0]   r_right;
    logic [3:0]     r_cr;        // chain: bit 0 = carry/shift bit, [3:0] = nibble
    logic [W-1:0]   r_shadow;
    logic           r_done;
    logic [W-1:0]   r_result;
    logic           r_c;
    logic           r_z;
    logic           r_ov;
    logic           r_s;

    logic           w_last;
    logic           w_msb_first;
    logic [KW-1:0]  w_sidx;
    logic [KW+2:0]  w_base;
    logic [7:0]     w_lb;
    logic [7:0]     w_rb;
    logic [7:0]     w_a;
    logic [7:0]     w_b;
    logic [7:0]     w_lo;
    logic [1:0]     w_hi;
    logic [7:0]     w_slice;
    logic [3:0]     w_cr_next;
    logic           w_c_sl;
    logic           w_ov_sl;
    logic [W-1:0]   w_shadow_next;
    logic [3:0]     w_seed;
`ifdef F8_ALU_WIDE_BCD_EN
    logic [4:0]     w_bl;
    logic [4:0]     w_bu;
`endif

    assign w_last      = (r_k == KW'(BYTES - 1));
    assign w_msb_first = (r_op == c_ALU_SR_1) || (r_op == c_ALU_SR_4);
    assign w_sidx      = w_msb_first ? (KW'(BYTES - 1) - r_k) : r_k;
    assign w_base      = {w_sidx, 3'b000};
    assign w_lb        = r_left[w_base +: 8];
    assign w_rb        = r_right[w_base +: 8];

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= c_ST_IDLE;
        else        r_state <= w_state_next;
    end

    // Next-state logic: one RUN pass of BYTES slices per accepted start
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE: if (start)  w_state_next = c_ST_RUN;
            c_ST_RUN:  if (w_last) w_state_next = c_ST_IDLE;
            default:               w_state_next = c_ST_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy = (r_state == c_ST_RUN);
    end

    // Slice-0 chain seed chosen from the op being launched
    always_comb begin
        w_seed = 4'h0;
        if (op == c_ALU_CMP)  w_seed = 4'h1;
        if (op == c_ALU_LINK) w_seed = {3'b000, c_in};
    end

    // Operand shaping for the adder-based ops
    always_comb begin
        w_a = w_lb;
        w_b = w_rb;
        case (r_op)
            c_ALU_INC:   w_b = (r_k == '0) ? 8'h01 : 8'h00;
            c_ALU_LINK:  w_b = 8'h00;
            c_ALU_CMP:   w_a = ~w_lb;
            c_ALU_DEC_R: w_a = 8'hFF;
            default:     ;
        endcase
    end

    // Split adder so carry into bit 7 is visible for the overflow term
    assign w_lo = {1'b0, w_a[6:0]} + {1'b0, w_b[6:0]} + {7'b0, r_cr[0]};
    assign w_hi = {1'b0, w_a[7]} + {1'b0, w_b[7]} + {1'b0, w_lo[7]};

`ifdef F8_ALU_WIDE_BCD_EN
    assign w_bl = {1'b0, w_lb[3:0]} + {1'b0, w_rb[3:0]} + {4'b0, r_cr[0]};
    assign w_bu = {1'b0, w_lb[7:4]} + {1'b0, w_rb[7:4]} + {4'b0, w_bl[4]};
`endif

    // Per-slice result, chain update and slice flags
    always_comb begin
        w_slice   = 8'h00;
        w_cr_next = 4'h0;
        w_c_sl    = 1'b0;
        w_ov_sl   = 1'b0;
        case (r_op)
`ifdef F8_ALU_WIDE_BCD_EN
            c_ALU_ADD_BCD: begin
                w_slice   = {w_bu[3:0] + (w_bu[4] ? 4'h0 : 4'hA),
                             w_bl[3:0] + (w_bl[4] ? 4'h0 : 4'hA)};
                w_cr_next = {3'b000, w_bu[4]};
                w_c_sl    = w_bu[4];
            end
            c_ALU_ADD, c_ALU_INC, c_ALU_LINK, c_ALU_CMP, c_ALU_DEC_R: begin
`else
            c_ALU_ADD, c_ALU_ADD_BCD, c_ALU_INC, c_ALU_LINK, c_ALU_CMP, c_ALU_DEC_R: begin
`endif
                w_slice   = {w_hi[0], w_lo[6:0]};
                w_cr_next = {3'b000, w_hi[1]};
                w_c_sl    = w_hi[1];
                w_ov_sl   = w_hi[1] ^ w_lo[7];
            end
            c_ALU_AND: w_slice = w_lb & w_rb;
            c_ALU_OR:  w_slice = w_lb | w_rb;
            c_ALU_XOR: w_slice = w_lb ^ w_rb;
            c_ALU_COM: w_slice = ~w_lb;
            c_ALU_L:   w_slice = w_lb;
            c_ALU_R:   w_slice = w_rb;
            c_ALU_SL_1: begin
                w_slice   = {w_lb[6:0], r_cr[0]};
                w_cr_next = {3'b000, w_lb[7]};
            end
            c_ALU_SR_1: begin
                w_slice   = {r_cr[0], w_lb[7:1]};
                w_cr_next = {3'b000, w_lb[0]};
            end
            c_ALU_SL_4: begin
                w_slice   = {w_lb[3:0], r_cr};
                w_cr_next = w_lb[7:4];
            end
            c_ALU_SR_4: begin
                w_slice   = {r_cr, w_lb[7:4]};
                w_cr_next = w_lb[3:0];
            end
            default: ;
        endcase
    end

    // Merge the current slice into the shadow copy of the result
    always_comb begin
        w_shadow_next                = r_shadow;
        w_shadow_next[w_base +: 8]   = w_slice;
    end

    // Datapath: capture at start, step slices, publish result on the last slice
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_k      <= '0;
            r_op     <= 4'h0;
            r_left   <= '0;
            r_right  <= '0;
            r_cr     <= 4'h0;
            r_shadow <= '0;
            r_done   <= 1'b0;
            r_result <= '0;
            r_c      <= 1'b0;
            r_z      <= 1'b0;
            r_ov     <= 1'b0;
            r_s      <= 1'b1;
        end else begin
            r_done <= 1'b0;
            if (r_state == c_ST_IDLE) begin
                if (start) begin
                    r_op     <= op;
                    r_left   <= left;
                    r_right  <= right;
                    r_cr     <= w_seed;
                    r_k      <= '0;
                    r_shadow <= '0;
                end
            end else begin
                r_shadow <= w_shadow_next;
                r_cr     <= w_cr_next;
                r_k      <= r_k + KW'(1);
                if (w_last) begin
                    r_done   <= 1'b1;
                    r_result <= w_shadow_next;
                    r_c      <= w_c_sl;
                    r_ov     <= w_ov_sl;
                    r_z      <= (w_shadow_next == '0);
                    r_s      <= ~w_shadow_next[W-1];
                end
            end
        end
    end

    assign done   = r_done;
    assign result = r_result;
    assign c      = r_c;
    assign z      = r_z;
    assign ov     = r_ov;
    assign s      = r_s;

endmodule

`default_nettype wire

// File: tb/tb_f8_alu_wide_seq.sv
// ============================================================================
//  Module      : tb_f8_alu_wide_seq
//  Description : Directed self-checking bench for f8_alu_wide_seq, BYTES=2.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_f8_alu_wide_seq;

    localparam logic [3:0] c_ADD = 4'd0,  c_ADD_BCD = 4'd1, c_INC = 4'd2,  c_LINK = 4'd3;
    localparam logic [3:0] c_CMP = 4'd4,  c_DEC_R   = 4'd5, c_AND = 4'd6,  c_OR   = 4'd7;
    localparam logic [3:0] c_XOR = 4'd8,  c_COM     = 4'd9, c_SL_1 = 4'd10, c_SL_4 = 4'd11;
    localparam logic [3:0] c_SR_1 = 4'd12, c_SR_4   = 4'd13, c_L   = 4'd14, c_R    = 4'd15;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [3:0]  op;
    logic [15:0] left;
    logic [15:0] right;
    logic        c_in;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic        c, z, ov, s;

    int n_vec = 0;
    int n_err = 0;

    f8_alu_wide_seq #(.BYTES(2)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .left(left), .right(right),
        .c_in(c_in), .busy(busy), .done(done), .result(result),
        .c(c), .z(z), .ov(ov), .s(s)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Launch one op (called at posedge+1), check busy, latency, result and flags
    task automatic run_op(input string tag, input logic [3:0] o, input logic [15:0] l,
                          input logic [15:0] r, input logic ci, input logic [15:0] er,
                          input logic ec, input logic ez, input logic eov, input logic es);
        int cyc;
        cyc   = 0;
        op    = o;
        left  = l;
        right = r;
        c_in  = ci;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        left  = 16'hDEAD;
        right = 16'hBEEF;
        c_in  = 1'b0;
        chk({tag, " busy"}, {31'b0, busy}, 32'd1);
        while (!done && cyc < 8) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk({tag, " latency"}, cyc, 32'd2);
        chk({tag, " result"}, {16'b0, result}, {16'b0, er});
        chk({tag, " c/z/ov/s"}, {28'b0, c, z, ov, s}, {28'b0, ec, ez, eov, es});
    endtask

    initial begin
        int ndone;
        rst_n = 1'b0; start = 1'b0; op = 4'h0; left = '0; right = '0; c_in = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("reset busy/done", {30'b0, busy, done}, 32'd0);
        chk("reset result", {16'b0, result}, 32'd0);
        chk("reset c/z/ov/s", {28'b0, c, z, ov, s}, 32'b0001);

        run_op("ADD 00FF+0001", c_ADD,   16'h00FF, 16'h0001, 1'b0, 16'h0100, 0, 0, 0, 1);
        // done must be a single-cycle pulse with the result held afterwards
        @(posedge clk); #1;
        chk("done pulse width", {31'b0, done}, 32'd0);
        chk("result held", {16'b0, result}, 32'h0100);

        run_op("ADD 7FFF+0001", c_ADD,   16'h7FFF, 16'h0001, 1'b0, 16'h8000, 0, 0, 1, 0);
        // back-to-back: the following starts are raised while done is high
        run_op("INC FFFF",      c_INC,   16'hFFFF, 16'h1234, 1'b0, 16'h0000, 1, 1, 0, 1);
        run_op("CMP 1234/1234", c_CMP,   16'h1234, 16'h1234, 1'b0, 16'h0000, 1, 1, 0, 1);
        run_op("LINK FFFF+1",   c_LINK,  16'hFFFF, 16'h5555, 1'b1, 16'h0000, 1, 1, 0, 1);
        run_op("DEC_R 0000",    c_DEC_R, 16'h1111, 16'h0000, 1'b0, 16'hFFFF, 0, 0, 0, 0);
        run_op("SR_1 0100",     c_SR_1,  16'h0100, 16'h0000, 1'b0, 16'h0080, 0, 0, 0, 1);
        run_op("SL_1 8080",     c_SL_1,  16'h8080, 16'h0000, 1'b0, 16'h0100, 0, 0, 0, 1);
        run_op("SL_4 0123",     c_SL_4,  16'h0123, 16'h0000, 1'b0, 16'h1230, 0, 0, 0, 1);
        run_op("SR_4 1230",     c_SR_4,  16'h1230, 16'h0000, 1'b0, 16'h0123, 0, 0, 0, 1);
        run_op("AND",           c_AND,   16'hF0F0, 16'h3C3C, 1'b0, 16'h3030, 0, 0, 0, 1);
        run_op("OR",            c_OR,    16'h8001, 16'h0100, 1'b0, 16'h8101, 0, 0, 0, 0);
        run_op("XOR",           c_XOR,   16'hFFFF, 16'h00FF, 1'b0, 16'hFF00, 0, 0, 0, 0);
        run_op("COM 0F0F",      c_COM,   16'h0F0F, 16'h0000, 1'b0, 16'hF0F0, 0, 0, 0, 0);
        run_op("L pass",        c_L,     16'h4321, 16'h9999, 1'b0, 16'h4321, 0, 0, 0, 1);
        run_op("R pass",        c_R,     16'h4321, 16'h0000, 1'b0, 16'h0000, 0, 1, 0, 1);
`ifdef F8_ALU_WIDE_BCD_EN
        run_op("ADD_BCD",       c_ADD_BCD, 16'h667F, 16'h0001, 1'b0, 16'h0020, 0, 0, 0, 1);
`else
        run_op("ADD_BCD bin",   c_ADD_BCD, 16'h667F, 16'h0001, 1'b0, 16'h6680, 0, 0, 0, 1);
`endif

        // start held while busy must be ignored: exactly one done, first op's result
        op = c_ADD; left = 16'h0001; right = 16'h0001; start = 1'b1;
        @(posedge clk); #1;
        op = c_XOR; left = 16'hFFFF; right = 16'h0000;
        ndone = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (done) ndone++;
        end
        chk("busy start ignored: done count", ndone, 32'd1);
        chk("busy start ignored: result", {16'b0, result}, 32'h0002);

        // reset during an op aborts it and restores reset outputs
        op = c_ADD; left = 16'h00FF; right = 16'h0001; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("mid-op reset busy/done", {30'b0, busy, done}, 32'd0);
        chk("mid-op reset result", {16'b0, result}, 32'd0);
        chk("mid-op reset c/z/ov/s", {28'b0, c, z, ov, s}, 32'b0001);
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (done || busy) ndone++;
        end
        chk("aborted op silent", ndone, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
